// File: rtl/poly_eval_unit_pkg.sv
// Shared definitions for the quadratic polynomial evaluator.
// Provides default operand widths, the controller state encoding and the
// encodings of the datapath mux selects (m0/m1/m2).
package poly_eval_unit_pkg;

  localparam int XW_DEF = 8;   // width of evaluation point X
  localparam int DW_DEF = 16;  // width of coefficients and result

  // Controller states, one clock each
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL1 = 3'd2,
    ADD1 = 3'd3,
    MUL2 = 3'd4,
    ADD2 = 3'd5,
    DONE = 3'd6
  } state_t;

  // m0: multiplier A-side source
  typedef enum logic {
    M0_AREG = 1'b0,
    M0_HREG = 1'b1
  } m0_sel_t;

  // m1: adder second operand source
  typedef enum logic {
    M1_BREG = 1'b0,
    M1_CREG = 1'b1
  } m1_sel_t;

  // m2: accumulator H load source
  typedef enum logic {
    M2_MUL = 1'b0,
    M2_ADD = 1'b1
  } m2_sel_t;

endpackage

// File: rtl/poly_eval_datapath.sv
// Shared-resource datapath for Horner evaluation ((A*X)+B)*X + C.
// One multiplier and one adder are time-multiplexed under controller selects.
// Ports:
//   ck, rst        clock and asynchronous active-low reset
//   lx             capture x/a/b/c into operand registers
//   lh             load accumulator H from the source chosen by m2
//   ls             load the result register from the adder output
//   m0, m1, m2     mux selects (multiplier A-side, adder B-side, H source)
//   x, a, b, c     raw operands from the host
//   resultado      last completed result (registered)
module poly_eval_datapath
  import poly_eval_unit_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          lx,
  input  logic          lh,
  input  logic          ls,
  input  m0_sel_t       m0,
  input  m1_sel_t       m1,
  input  m2_sel_t       m2,
  input  logic [XW-1:0] x,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  output logic [DW-1:0] resultado
);

  logic [XW-1:0] x_r;
  logic [DW-1:0] a_r;
  logic [DW-1:0] b_r;
  logic [DW-1:0] c_r;
  logic [DW-1:0] h_r;
  logic [DW-1:0] res_r;

  logic [DW-1:0] mul_a_s;
  logic [DW-1:0] add_b_s;
  logic [DW-1:0] prod_s;
  logic [DW-1:0] sum_s;
  logic [DW-1:0] h_src_s;

  // Operand muxes plus the shared multiplier and adder
  always_comb begin
    mul_a_s = a_r;
    add_b_s = b_r;
    h_src_s = prod_s;
    case (m0)
      M0_AREG: mul_a_s = a_r;
      M0_HREG: mul_a_s = h_r;
      default: mul_a_s = a_r;
    endcase
    case (m1)
      M1_BREG: add_b_s = b_r;
      M1_CREG: add_b_s = c_r;
      default: add_b_s = b_r;
    endcase
    // Only the low DW bits of the product are ever kept, so X is
    // zero-extended to DW and the multiply done at DW width.
    prod_s = mul_a_s * {{(DW-XW){1'b0}}, x_r};
    sum_s  = h_r + add_b_s;
    case (m2)
      M2_MUL:  h_src_s = prod_s;
      M2_ADD:  h_src_s = sum_s;
      default: h_src_s = prod_s;
    endcase
  end

  // Operand, accumulator and result registers
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      x_r   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= '0;
      h_r   <= '0;
      res_r <= '0;
    end else begin
      if (lx) begin
        x_r <= x;
        a_r <= a;
        b_r <= b;
        c_r <= c;
      end
      if (lh) begin
        h_r <= h_src_s;
      end
      // The final H+C goes straight to the result in the same edge
      if (ls) begin
        res_r <= sum_s;
      end
    end
  end

  assign resultado = res_r;

endmodule

// File: rtl/poly_eval_unit.sv
// Quadratic polynomial evaluator: Resultado = A*X*X + B*X + C (mod 2^DW).
// Controller FSM sequences a shared multiplier/adder datapath through
// LOAD, MUL1, ADD1, MUL2, ADD2, DONE with an inicio/pronto handshake.
// Ports:
//   ck, rst        clock and asynchronous active-low reset
//   inicio         start request, honoured only while idle
//   X, A, B, C     evaluation point and coefficients (unsigned)
//   Resultado      last completed result, held until the next run or reset
//   pronto         one-cycle completion pulse (high during DONE)
//   ocupado        high in every state except IDLE
module poly_eval_unit
  import poly_eval_unit_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          inicio,
  input  logic [XW-1:0] X,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [DW-1:0] C,
  output logic [DW-1:0] Resultado,
  output logic          pronto,
  output logic          ocupado
);

  state_t  state_r;
  state_t  state_next_s;
  logic    lx_s;
  logic    lh_s;
  logic    ls_s;
  m0_sel_t m0_s;
  m1_sel_t m1_s;
  m2_sel_t m2_s;
  logic    pronto_r;
  logic    ocupado_r;

  // Next-state and datapath control decode
  always_comb begin
    state_next_s = state_r;
    lx_s         = 1'b0;
    lh_s         = 1'b0;
    ls_s         = 1'b0;
    m0_s         = M0_AREG;
    m1_s         = M1_BREG;
    m2_s         = M2_MUL;
    case (state_r)
      IDLE: begin
        if (inicio) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        lx_s         = 1'b1;
        state_next_s = MUL1;
      end
      MUL1: begin
        lh_s         = 1'b1;
        m0_s         = M0_AREG;
        m2_s         = M2_MUL;
        state_next_s = ADD1;
      end
      ADD1: begin
        lh_s         = 1'b1;
        m1_s         = M1_BREG;
        m2_s         = M2_ADD;
        state_next_s = MUL2;
      end
      MUL2: begin
        lh_s         = 1'b1;
        m0_s         = M0_HREG;
        m2_s         = M2_MUL;
        state_next_s = ADD2;
      end
      ADD2: begin
        lh_s         = 1'b1;
        ls_s         = 1'b1;
        m1_s         = M1_CREG;
        m2_s         = M2_ADD;
        state_next_s = DONE;
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register; status flags are registered from the next state so
  // they line up exactly with the state they describe
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      pronto_r  <= 1'b0;
      ocupado_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      pronto_r  <= (state_next_s == DONE);
      ocupado_r <= (state_next_s != IDLE);
    end
  end

  assign pronto  = pronto_r;
  assign ocupado = ocupado_r;

  poly_eval_datapath #(
    .XW(XW),
    .DW(DW)
  ) u_datapath (
    .ck       (ck),
    .rst      (rst),
    .lx       (lx_s),
    .lh       (lh_s),
    .ls       (ls_s),
    .m0       (m0_s),
    .m1       (m1_s),
    .m2       (m2_s),
    .x        (X),
    .a        (A),
    .b        (B),
    .c        (C),
    .resultado(Resultado)
  );

endmodule

// File: tb/tb_poly_eval_unit.sv
// Self-checking bench for poly_eval_unit: directed cases plus randomized
// runs compared against a plain-arithmetic polynomial model.
module tb_poly_eval_unit;

  logic        ck;
  logic        rst;
  logic        inicio;
  logic [7:0]  X;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] C;
  logic [15:0] Resultado;
  logic        pronto;
  logic        ocupado;

  int          total;
  int          bad;
  logic [15:0] res_model;

  poly_eval_unit dut (
    .ck       (ck),
    .rst      (rst),
    .inicio   (inicio),
    .X        (X),
    .A        (A),
    .B        (B),
    .C        (C),
    .Resultado(Resultado),
    .pronto   (pronto),
    .ocupado  (ocupado)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Reference: the polynomial itself, reduced mod 2^16
  function automatic logic [15:0] model(input longint unsigned x, input longint unsigned a,
                                        input longint unsigned b, input longint unsigned c);
    longint unsigned v;
    v = a * x * x + b * x + c;
    return v[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full run from idle; checks every busy cycle. Called just after a
  // falling edge with the unit idle. Operands are scrambled after capture.
  task automatic run_std(input logic [7:0] x, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input string tag);
    logic [15:0] exp;
    exp = model(x, a, b, c);
    X = x; A = a; B = b; C = c;
    inicio = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge ck);
      if (k == 1) inicio = 1'b0;
      if (k == 2) begin
        X = 8'($urandom); A = 16'($urandom); B = 16'($urandom); C = 16'($urandom);
      end
      check({tag, "/ocupado"}, 32'(ocupado), 32'd1);
      check({tag, "/pronto"}, 32'(pronto), (k == 6) ? 32'd1 : 32'd0);
      check({tag, "/res"}, 32'(Resultado), (k == 6) ? 32'(exp) : 32'(res_model));
    end
    res_model = exp;
    @(negedge ck);
    check({tag, "/idle_ocupado"}, 32'(ocupado), 32'd0);
    check({tag, "/idle_pronto"}, 32'(pronto), 32'd0);
    check({tag, "/hold_res"}, 32'(Resultado), 32'(exp));
  endtask

  initial begin
    int          npulse;
    int          last_cyc;
    logic [7:0]  rx;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] rc;

    total = 0; bad = 0; res_model = 16'd0;
    rst = 1'b0; inicio = 1'b0;
    X = 8'd0; A = 16'd0; B = 16'd0; C = 16'd0;

    // Reset state
    #3;
    check("reset/res", 32'(Resultado), 32'd0);
    check("reset/pronto", 32'(pronto), 32'd0);
    check("reset/ocupado", 32'(ocupado), 32'd0);
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);

    // Basic and boundary cases
    run_std(8'd2, 16'd3, 16'd4, 16'd5, "basic");
    check("basic/value", 32'(Resultado), 32'd25);
    run_std(8'd255, 16'hFFFF, 16'h0000, 16'h0001, "wrap");
    check("wrap/value", 32'(Resultado), 32'h0200);
    run_std(8'd0, 16'h1234, 16'h5678, 16'h00AB, "x_zero");
    check("x_zero/value", 32'(Resultado), 32'h00AB);
    run_std(8'd1, 16'd1, 16'd1, 16'd1, "ones");
    check("ones/value", 32'(Resultado), 32'd3);

    // Operand change in MUL1 and a stray start in ADD1 are both ignored
    X = 8'd2; A = 16'd3; B = 16'd4; C = 16'd5;
    inicio = 1'b1;
    @(negedge ck); inicio = 1'b0;      // LOAD
    @(negedge ck); A = 16'd100;        // MUL1
    @(negedge ck); inicio = 1'b1;      // ADD1
    @(negedge ck); inicio = 1'b0;
    npulse = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge ck);
      if (pronto) npulse++;
    end
    check("ignore/pulses", 32'(npulse), 32'd1);
    check("ignore/res", 32'(Resultado), 32'd25);
    check("ignore/ocupado", 32'(ocupado), 32'd0);
    res_model = 16'd25;

    // Asynchronous reset during MUL2
    X = 8'd3; A = 16'd7; B = 16'd9; C = 16'd11;
    inicio = 1'b1;
    @(negedge ck); inicio = 1'b0;      // LOAD
    @(negedge ck);                     // MUL1
    @(negedge ck);                     // ADD1
    @(negedge ck);                     // MUL2
    #2 rst = 1'b0;
    #1;
    check("abort/res", 32'(Resultado), 32'd0);
    check("abort/pronto", 32'(pronto), 32'd0);
    check("abort/ocupado", 32'(ocupado), 32'd0);
    @(negedge ck); rst = 1'b1;
    res_model = 16'd0;
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge ck);
      if (ocupado || pronto) npulse++;
    end
    check("abort/stays_idle", 32'(npulse), 32'd0);
    check("abort/res_hold", 32'(Resultado), 32'd0);

    // inicio held high for 20 cycles: back-to-back runs, 7-cycle spacing
    X = 8'd1; A = 16'd1; B = 16'd1; C = 16'd1;
    inicio = 1'b1;
    npulse = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge ck);
      if (cyc == 19) inicio = 1'b0;
      if (pronto) begin
        if (npulse > 0) check("held/spacing", 32'(cyc - last_cyc), 32'd7);
        check("held/res", 32'(Resultado), 32'd3);
        npulse++;
        last_cyc = cyc;
      end
    end
    check("held/pulses", 32'(npulse), 32'd3);
    check("held/ocupado", 32'(ocupado), 32'd0);
    res_model = 16'd3;

    // Randomized runs against the model
    for (int i = 0; i < 16; i++) begin
      rx = 8'($urandom); ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom);
      if (i == 0) rx = 8'd255;
      run_std(rx, ra, rb, rc, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
